// File: rtl/fsm_example_pkg.sv
// Shared constants and types for the a/b FSM driver: state indices,
// dout encodings, stimulus code table, response codes, driver states.
package fsm_example_pkg;

  localparam logic [1:0] S0      = 2'd0;
  localparam logic [1:0] S1      = 2'd1;
  localparam logic [1:0] S2      = 2'd2;
  localparam logic [1:0] TGT_BAD = 2'd3;

  localparam logic [2:0] DOUT_S0 = 3'd1;
  localparam logic [2:0] DOUT_S1 = 3'd2;
  localparam logic [2:0] DOUT_S2 = 3'd3;

  localparam logic [1:0] RESP_OK           = 2'd0;
  localparam logic [1:0] RESP_TIMEOUT      = 2'd1;
  localparam logic [1:0] RESP_BAD_TARGET   = 2'd2;
  localparam logic [1:0] RESP_BAD_FEEDBACK = 2'd3;

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} drv_state_e;

  typedef struct packed {
    logic a;
    logic b;
  } ab_code_t;

  // One-cycle stimulus that forces the FSM into state idx; hold otherwise.
  function automatic ab_code_t ab_code(input logic [1:0] idx);
    ab_code_t c;
    case (idx)
      S0:      c = '{a: 1'b1, b: 1'b0};
      S1:      c = '{a: 1'b0, b: 1'b1};
      S2:      c = '{a: 1'b1, b: 1'b1};
      default: c = '{a: 1'b0, b: 1'b0};
    endcase
    return c;
  endfunction

  // dout value the FSM shows while sitting in state idx.
  function automatic logic [2:0] dout_of(input logic [1:0] idx);
    case (idx)
      S0:      dout_of = DOUT_S0;
      S1:      dout_of = DOUT_S1;
      default: dout_of = DOUT_S2;
    endcase
  endfunction

endpackage

// File: rtl/fsm_example_driver_if.sv
// Command/response channel, a/b stimulus and dout feedback of the driver.
interface fsm_example_driver_if #(parameter int CNT_W = 16);
  logic             req_vld;
  logic             req_rdy;
  logic [1:0]       req_target;
  logic             a;
  logic             b;
  logic [2:0]       fb_state;
  logic             resp_vld;
  logic             resp_rdy;
  logic [1:0]       resp_code;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  // Driver side.
  modport master (
    input  req_vld, req_target, fb_state, resp_rdy,
    output req_rdy, a, b, resp_vld, resp_code, cnt_ok, cnt_err
  );

  // Bus / bench side.
  modport slave (
    output req_vld, req_target, fb_state, resp_rdy,
    input  req_rdy, a, b, resp_vld, resp_code, cnt_ok, cnt_err
  );
endinterface

// File: rtl/fsm_example_driver_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);
  // Count up on inc until all-ones.
  always_ff @(posedge clk) begin
    if (rst)                    value <= '0;
    else if (inc && value != '1) value <= value + WIDTH'(1);
  end
endmodule

// File: rtl/fsm_example_driver.sv
// Initiator-side driver for the 3-state a/b FSM: takes a target state,
// pulses its a/b code for one cycle, watches dout until it matches or
// times out, and reports a status code with ok/error statistics.
module fsm_example_driver
  import fsm_example_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  fsm_example_driver_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  drv_state_e    r_state;
  logic          r_a, r_b;
  logic          r_req_rdy;
  logic          r_resp_vld;
  logic [1:0]    r_resp_code;
  logic [1:0]    r_tgt;
  logic [TW-1:0] r_tcnt;

  logic w_resp_hs, w_inc_ok, w_inc_err, w_fb_bad;

  assign w_resp_hs = r_resp_vld & bus.resp_rdy;
  assign w_inc_ok  = w_resp_hs & (r_resp_code == RESP_OK);
  assign w_inc_err = w_resp_hs & (r_resp_code != RESP_OK);
  assign w_fb_bad  = (bus.fb_state == 3'd0) || (bus.fb_state > DOUT_S2);

  // Driver FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_req_rdy   <= 1'b1;
      r_resp_vld  <= 1'b0;
      r_resp_code <= RESP_OK;
      r_tgt       <= S0;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_vld && r_req_rdy) begin
          r_req_rdy <= 1'b0;
          if (bus.req_target == TGT_BAD) begin
            r_resp_code <= RESP_BAD_TARGET;
            r_resp_vld  <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_tgt      <= bus.req_target;
            {r_a, r_b} <= ab_code(bus.req_target);
            r_state    <= DRIVE;
          end
        end
        DRIVE: begin
          r_a     <= 1'b0;
          r_b     <= 1'b0;
          r_tcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Match wins over bad feedback, which wins over timeout.
          if (bus.fb_state == dout_of(r_tgt)) begin
            r_resp_code <= RESP_OK;
            r_resp_vld  <= 1'b1;
            r_state     <= RESP;
          end else if (w_fb_bad) begin
            r_resp_code <= RESP_BAD_FEEDBACK;
            r_resp_vld  <= 1'b1;
            r_state     <= RESP;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_resp_code <= RESP_TIMEOUT;
            r_resp_vld  <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        RESP: if (bus.resp_rdy) begin
          r_resp_vld <= 1'b0;
          r_req_rdy  <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt_ok (
    .clk(clk), .rst(rst), .inc(w_inc_ok), .value(bus.cnt_ok)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_err (
    .clk(clk), .rst(rst), .inc(w_inc_err), .value(bus.cnt_err)
  );

  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.req_rdy   = r_req_rdy;
  assign bus.resp_vld  = r_resp_vld;
  assign bus.resp_code = r_resp_code;
endmodule

// File: tb/tb_fsm_example_driver.sv
// Random + directed bench for fsm_example_driver, driving a behavioural
// model of the target a/b FSM and checking against a transaction model.
module tb_fsm_example_driver;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsm_example_driver_if #(.CNT_W(16)) if0 ();
  fsm_example_driver_if #(.CNT_W(2))  if1 ();

  fsm_example_driver #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(if0.master));
  fsm_example_driver #(.TIMEOUT(TIMEOUT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if1.master));

  // Second DUT sees identical stimulus; only its counter width differs.
  assign if1.req_vld    = if0.req_vld;
  assign if1.req_target = if0.req_target;
  assign if1.resp_rdy   = if0.resp_rdy;
  assign if1.fb_state   = if0.fb_state;

  // Target FSM: a/b code forces a state, 00 holds. Feedback may be overridden.
  int       fsm_st = 0;
  bit       fb_conn = 1'b1;
  logic [2:0] fb_force = 3'd1;
  always @(posedge clk)
    if (rst) fsm_st <= 0;
    else if (if0.a && !if0.b) fsm_st <= 0;
    else if (!if0.a && if0.b) fsm_st <= 1;
    else if (if0.a && if0.b)  fsm_st <= 2;
  assign if0.fb_state = fb_conn ? 3'(fsm_st + 1) : fb_force;

  int n_cmp = 0, n_bad = 0, cyc_n = 0, acc = 0, ab_cnt = 0;
  bit started = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endfunction

  // Transaction model: outstanding command, edges since acceptance, result.
  int m_busy = 0, m_resp = 0, m_age = 0, m_tgt = 0, m_code = 0, m_ok = 0, m_err = 0;
  always @(posedge clk) begin
    cyc_n++;
    started = 1'b1;
    if (rst) begin
      m_busy = 0; m_resp = 0; m_age = 0; m_tgt = 0; m_code = 0; m_ok = 0; m_err = 0;
    end else if (m_busy == 0) begin
      if (if0.req_vld) begin
        m_busy = 1;
        if (if0.req_target == 2'd3) begin m_resp = 1; m_code = 2; end
        else begin m_resp = 0; m_age = 0; m_tgt = int'(if0.req_target); end
      end
    end else if (m_resp == 1) begin
      if (if0.resp_rdy) begin
        if (m_code == 0) m_ok++; else m_err++;
        m_busy = 0; m_resp = 0;
      end
    end else begin
      m_age++;
      if (m_age >= 2) begin
        if (int'(if0.fb_state) == m_tgt + 1)                begin m_resp = 1; m_code = 0; end
        else if (if0.fb_state == 0 || if0.fb_state > 3)     begin m_resp = 1; m_code = 3; end
        else if (m_age - 2 == TIMEOUT - 1)                  begin m_resp = 1; m_code = 1; end
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) if (started) begin
    int ea, eb;
    bit drv;
    drv = (m_busy == 1) && (m_resp == 0) && (m_age == 0);
    ea = (drv && m_tgt != 1) ? 1 : 0;
    eb = (drv && m_tgt != 0) ? 1 : 0;
    if (if0.a || if0.b) ab_cnt++;
    chk("a", int'(if0.a), ea);
    chk("b", int'(if0.b), eb);
    chk("req_rdy", int'(if0.req_rdy), (m_busy == 0) ? 1 : 0);
    chk("resp_vld", int'(if0.resp_vld), m_resp);
    if (m_resp == 1) chk("resp_code", int'(if0.resp_code), m_code);
    chk("cnt_ok", int'(if0.cnt_ok), sat(m_ok, 65535));
    chk("cnt_err", int'(if0.cnt_err), sat(m_err, 65535));
    chk("cnt_ok_w2", int'(if1.cnt_ok), sat(m_ok, 3));
    chk("cnt_err_w2", int'(if1.cnt_err), sat(m_err, 3));
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] t);
    bit got, was;
    got = 0;
    ab_cnt = 0;
    if0.req_vld = 1'b1;
    if0.req_target = t;
    for (int i = 0; i < 50 && !got; i++) begin
      was = if0.req_rdy;
      cyc();
      if (was) got = 1;
    end
    if (!got) chk("accept_bound", 0, 1);
    acc = cyc_n;
    if0.req_vld = 1'b0;
  endtask

  task automatic get_resp(input int hold, output int lat, output int code);
    bit found;
    found = 0;
    if0.resp_rdy = (hold == 0);
    for (int i = 0; i < 40 && !found; i++) begin
      if (if0.resp_vld) found = 1;
      else cyc();
    end
    if (!found) chk("resp_bound", 0, 1);
    lat  = cyc_n - acc;
    code = int'(if0.resp_code);
    repeat (hold) cyc();
    if0.resp_rdy = 1'b1;
    cyc();
  endtask

  initial begin
    int lat, code, okb;
    int seq[4] = '{1, 0, 2, 2};
    if0.req_vld = 1'b0; if0.req_target = 2'd0; if0.resp_rdy = 1'b1;
    rst = 1'b1;
    cyc();
    chk("rst_req_rdy", int'(if0.req_rdy), 1);
    chk("rst_resp_vld", int'(if0.resp_vld), 0);
    chk("rst_ab", int'({if0.a, if0.b}), 0);
    chk("rst_cnt_ok", int'(if0.cnt_ok), 0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Target S2 from S0.
    send(2'd2); get_resp(0, lat, code);
    chk("t1_latency", lat, 2);
    chk("t1_code", code, 0);
    chk("t1_fb", int'(if0.fb_state), 3);
    chk("t1_ab_cycles", ab_cnt, 1);
    chk("t1_cnt_ok", int'(if0.cnt_ok), 1);

    // Back-to-back targets, including a repeat of the current state.
    foreach (seq[i]) begin
      send(2'(seq[i])); get_resp(0, lat, code);
      chk("t2_code", code, 0);
      chk("t2_latency", lat, 2);
      chk("t2_ab_cycles", ab_cnt, 1);
    end
    chk("t2_cnt_ok", int'(if0.cnt_ok), 5);

    // Illegal target.
    send(2'd3); get_resp(0, lat, code);
    chk("t3_latency", lat, 0);
    chk("t3_code", code, 2);
    chk("t3_ab_cycles", ab_cnt, 0);
    chk("t3_cnt_err", int'(if0.cnt_err), 1);

    // Stuck feedback -> timeout, then out-of-range feedback.
    fb_conn = 1'b0; fb_force = 3'd1;
    send(2'd1); get_resp(0, lat, code);
    chk("t4_to_latency", lat, TIMEOUT + 1);
    chk("t4_to_code", code, 1);
    fb_force = 3'd0;
    send(2'd0); get_resp(0, lat, code);
    chk("t4_bf_latency", lat, 2);
    chk("t4_bf_code", code, 3);
    chk("t4_cnt_err", int'(if0.cnt_err), 3);
    fb_conn = 1'b1;

    // Backpressure with a competing request.
    send(2'd0);
    if0.resp_rdy = 1'b0;
    repeat (3) cyc();
    chk("t5_resp_vld", int'(if0.resp_vld), 1);
    okb = int'(if0.cnt_ok);
    if0.req_vld = 1'b1; if0.req_target = 2'd2;
    repeat (5) cyc();
    chk("t5_cnt_frozen", int'(if0.cnt_ok), okb);
    chk("t5_req_rdy", int'(if0.req_rdy), 0);
    chk("t5_code", int'(if0.resp_code), 0);
    if0.req_vld = 1'b0; if0.resp_rdy = 1'b1;
    cyc();
    chk("t5_cnt_after", int'(if0.cnt_ok), okb + 1);

    // Reset during WAIT drops the command.
    send(2'd2);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_req_rdy", int'(if0.req_rdy), 1);
    chk("t6_resp_vld", int'(if0.resp_vld), 0);
    chk("t6_ab", int'({if0.a, if0.b}), 0);
    chk("t6_cnt_ok", int'(if0.cnt_ok), 0);
    chk("t6_cnt_err", int'(if0.cnt_err), 0);
    repeat (3) cyc();
    chk("t6_no_resp", int'(if0.resp_vld), 0);

    // Saturation on the narrow counter.
    repeat (5) begin send(2'd0); get_resp(0, lat, code); end
    chk("t6_sat_w2", int'(if1.cnt_ok), 3);
    chk("t6_ok_w16", int'(if0.cnt_ok), 5);

    // Randomized commands, feedback faults and backpressure.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        fb_conn = 1'b0; fb_force = 3'($urandom_range(0, 7));
      end else fb_conn = 1'b1;
      send(2'($urandom_range(0, 3)));
      get_resp(int'($urandom_range(0, 3)), lat, code);
      repeat ($urandom_range(0, 2)) cyc();
    end
    fb_conn = 1'b1;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
